// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences exception/interrupt entry and mret return into CSR writes and a fetch redirect
module trap_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_valid,
    input  logic [30:0] exc_cause,
    input  logic [31:0] exc_pc,
    input  logic [31:0] exc_val,
    input  logic        mret_req,
    input  logic [31:0] int_pc,
    input  logic [31:0] mtvec_in,
    input  logic [31:0] mepc_in,
    input  logic        mstatus_mie_in,
    input  logic        mstatus_mpie_in,
    input  logic        mip_msip_in,
    input  logic        mip_mtip_in,
    input  logic        mip_meip_in,
    input  logic        mie_msie_in,
    input  logic        mie_mtie_in,
    input  logic        mie_meie_in,
    output logic        trap_mie,
    output logic        trap_mpie,
    output logic [31:0] trap_pc_in,
    output logic        trap_int,
    output logic [30:0] trap_cause,
    output logic [31:0] trap_val,
    output logic        trap_wr_en,
    output logic        mret_wr_en,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        stall
);
    typedef enum logic [1:0] {IDLE, TRAP, MRET, REDIR} state_t;
    state_t state, state_nxt;
    logic irq;
    logic [30:0] irq_cause;
    logic [31:0] base, target;

    assign irq = mstatus_mie_in & ((mip_meip_in & mie_meie_in) | (mip_msip_in & mie_msie_in) |
                                   (mip_mtip_in & mie_mtie_in));
    assign irq_cause = (mip_meip_in & mie_meie_in) ? 31'd11 :
                       (mip_msip_in & mie_msie_in) ? 31'd3 : 31'd7;
    assign base   = {mtvec_in[31:2], 2'b00};
    assign target = (mtvec_in[1:0] == 2'b01 && trap_int) ? base + {trap_cause[29:0], 2'b00} : base;

    assign trap_wr_en     = state == TRAP;
    assign mret_wr_en     = state == MRET;
    assign redirect_valid = state == REDIR;
    assign stall          = state != IDLE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        if (state == IDLE)
            state_nxt = exc_valid ? TRAP : mret_req ? MRET : irq ? TRAP : IDLE;
        else if (state != REDIR)
            state_nxt = REDIR;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trap_mie    <= 1'b0;
            trap_mpie   <= 1'b0;
            trap_pc_in  <= '0;
            trap_int    <= 1'b0;
            trap_cause  <= '0;
            trap_val    <= '0;
            redirect_pc <= '0;
        end else begin
            if (state == IDLE && (exc_valid || (!mret_req && irq))) begin
                trap_mie   <= 1'b0;
                trap_mpie  <= mstatus_mie_in;
                trap_int   <= !exc_valid;
                trap_cause <= exc_valid ? exc_cause : irq_cause;
                trap_pc_in <= exc_valid ? exc_pc : int_pc;
                trap_val   <= exc_valid ? exc_val : 32'd0;
            end else if (state == IDLE && mret_req) begin
                trap_mie  <= mstatus_mpie_in;
                trap_mpie <= 1'b1;
            end
            // redirect target is latched from the CSR values seen during the write cycle
            if (state == TRAP) redirect_pc <= target;
            if (state == MRET) redirect_pc <= mepc_in;
        end
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: randomized and directed checks of trap_ctrl against a transaction-level model
module tb_trap_ctrl;
    logic        clk = 1'b0, reset = 1'b0;
    logic        exc_valid, mret_req;
    logic [30:0] exc_cause;
    logic [31:0] exc_pc, exc_val, int_pc, mtvec_in, mepc_in;
    logic        mstatus_mie_in, mstatus_mpie_in, mip_msip_in, mip_mtip_in, mip_meip_in;
    logic        mie_msie_in, mie_mtie_in, mie_meie_in;
    logic        trap_mie, trap_mpie, trap_int, trap_wr_en, mret_wr_en, redirect_valid, stall;
    logic [31:0] trap_pc_in, trap_val, redirect_pc;
    logic [30:0] trap_cause;

    int checks = 0, failures = 0;
    logic        m_mie, m_mpie, m_int;
    logic [30:0] m_cause;
    logic [31:0] m_pc, m_val;

    trap_ctrl dut (
        .clk(clk), .reset(reset), .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
        .exc_val(exc_val), .mret_req(mret_req), .int_pc(int_pc), .mtvec_in(mtvec_in),
        .mepc_in(mepc_in), .mstatus_mie_in(mstatus_mie_in), .mstatus_mpie_in(mstatus_mpie_in),
        .mip_msip_in(mip_msip_in), .mip_mtip_in(mip_mtip_in), .mip_meip_in(mip_meip_in),
        .mie_msie_in(mie_msie_in), .mie_mtie_in(mie_mtie_in), .mie_meie_in(mie_meie_in),
        .trap_mie(trap_mie), .trap_mpie(trap_mpie), .trap_pc_in(trap_pc_in), .trap_int(trap_int),
        .trap_cause(trap_cause), .trap_val(trap_val), .trap_wr_en(trap_wr_en),
        .mret_wr_en(mret_wr_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        {exc_valid, mret_req, mstatus_mie_in, mstatus_mpie_in, mip_msip_in, mip_mtip_in,
         mip_meip_in, mie_msie_in, mie_mtie_in, mie_meie_in} = '0;
        exc_cause = '0; exc_pc = '0; exc_val = '0; int_pc = '0; mtvec_in = '0; mepc_in = '0;
    endtask

    task automatic rand_inputs();
        exc_valid = $urandom_range(0, 3) == 0;
        mret_req  = $urandom_range(0, 3) == 0;
        exc_cause = 31'($urandom);
        exc_pc = $urandom; exc_val = $urandom; int_pc = $urandom; mepc_in = $urandom;
        mtvec_in = $urandom_range(0, 1) ? {$urandom} & ~32'h3 | 32'h1 : $urandom;
        {mstatus_mie_in, mstatus_mpie_in, mip_msip_in, mip_mtip_in, mip_meip_in,
         mie_msie_in, mie_mtie_in, mie_meie_in} = 8'($urandom);
    endtask

    task automatic check_data(input string tag);
        check({tag, ".mie"}, trap_mie, m_mie);
        check({tag, ".mpie"}, trap_mpie, m_mpie);
        check({tag, ".int"}, trap_int, m_int);
        check({tag, ".cause"}, trap_cause, m_cause);
        check({tag, ".pc"}, trap_pc_in, m_pc);
        check({tag, ".val"}, trap_val, m_val);
    endtask

    task automatic check_ctl(input string tag, input logic tw, input logic mw, input logic rv,
                             input logic st);
        check({tag, ".trap_wr_en"}, trap_wr_en, tw);
        check({tag, ".mret_wr_en"}, mret_wr_en, mw);
        check({tag, ".redirect_valid"}, redirect_valid, rv);
        check({tag, ".stall"}, stall, st);
    endtask

    // One visit to IDLE: predict the accepted request from the inputs now present, then follow
    // it through write and redirect cycles. With noisy=0 the requester holds its inputs.
    task automatic run_txn(input string tag, input bit noisy);
        int kind, code;
        logic [31:0] tgt;
        code = !mstatus_mie_in ? 0 : (mip_meip_in && mie_meie_in) ? 11 :
               (mip_msip_in && mie_msie_in) ? 3 : (mip_mtip_in && mie_mtie_in) ? 7 : 0;
        kind = exc_valid ? 1 : mret_req ? 2 : code != 0 ? 3 : 0;
        if (kind == 1 || kind == 3) begin
            m_mie = 1'b0; m_mpie = mstatus_mie_in; m_int = kind == 3;
            m_cause = kind == 1 ? exc_cause : 31'(code);
            m_pc = kind == 1 ? exc_pc : int_pc;
            m_val = kind == 1 ? exc_val : 32'd0;
        end else if (kind == 2) begin
            m_mie = mstatus_mpie_in; m_mpie = 1'b1;
        end
        step();
        if (kind == 0) begin
            check_ctl({tag, ".idle"}, 0, 0, 0, 0);
            check_data({tag, ".idle"});
            return;
        end
        check_ctl({tag, ".wr"}, kind != 2, kind == 2, 0, 1);
        check_data({tag, ".wr"});
        if (noisy) rand_inputs();
        tgt = kind == 2 ? mepc_in :
              (mtvec_in % 4 == 1 && m_int) ? (mtvec_in / 4) * 4 + 32'(m_cause) * 4 :
              (mtvec_in / 4) * 4;
        step();
        check_ctl({tag, ".redir"}, 0, 0, 1, 1);
        check({tag, ".redirect_pc"}, redirect_pc, tgt);
        check_data({tag, ".redir"});
        if (noisy) rand_inputs();
        step();
        check_ctl({tag, ".back"}, 0, 0, 0, 0);
    endtask

    initial begin
        quiet();
        {m_mie, m_mpie, m_int} = '0; m_cause = '0; m_pc = '0; m_val = '0;
        #1;
        check_ctl("reset", 0, 0, 0, 0);
        check_data("reset");
        check("reset.redirect_pc", redirect_pc, 0);
        step(); step();
        reset = 1'b1;
        exc_valid = 1'b1; exc_cause = 31'd2; exc_pc = 32'h8AB4; exc_val = 32'hFFEEDD11;
        mstatus_mie_in = 1'b1; mtvec_in = 32'h4;
        run_txn("exc_first", 0);

        quiet();
        mstatus_mie_in = 1'b1; mip_meip_in = 1'b1; mie_meie_in = 1'b1;
        mip_mtip_in = 1'b1; mie_mtie_in = 1'b1; mtvec_in = 32'h101; int_pc = 32'h8A9C;
        run_txn("irq_mei", 0);

        quiet();
        mstatus_mie_in = 1'b1; mip_msip_in = 1'b1; mie_msie_in = 1'b1;
        mip_mtip_in = 1'b1; mie_mtie_in = 1'b1; mtvec_in = 32'hFFFF_FFF1; int_pc = 32'h40;
        run_txn("irq_msi_wrap", 0);

        quiet();
        exc_valid = 1'b1; exc_cause = 31'd5; exc_pc = 32'h100; mret_req = 1'b1;
        mstatus_mie_in = 1'b1; mip_mtip_in = 1'b1; mie_mtie_in = 1'b1; mtvec_in = 32'h301;
        run_txn("exc_over_mret", 0);

        quiet();
        mret_req = 1'b1; mstatus_mpie_in = 1'b1; mepc_in = 32'h200;
        run_txn("mret", 0);

        quiet();
        mip_meip_in = 1'b1; mie_meie_in = 1'b1; mip_mtip_in = 1'b1; mie_mtie_in = 1'b1;
        for (int i = 0; i < 10; i++) run_txn("masked", 0);

        exc_valid = 1'b1; exc_cause = 31'd7; exc_pc = 32'h44; mtvec_in = 32'h1000;
        run_txn("exc_held", 0);

        quiet();
        exc_valid = 1'b1; exc_cause = 31'd3; mstatus_mie_in = 1'b1;
        step();
        check("rst_mid.in_trap", trap_wr_en, 1);
        reset = 1'b0;
        #1;
        {m_mie, m_mpie, m_int} = '0; m_cause = '0; m_pc = '0; m_val = '0;
        check_ctl("rst_mid", 0, 0, 0, 0);
        check_data("rst_mid");
        check("rst_mid.redirect_pc", redirect_pc, 0);
        quiet();
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_ctl("post_rst", 0, 0, 0, 0);
        end

        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            run_txn("rand", 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
